vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY counters with registered hs/vs/blank and frame pulse.
// Define VGA_SYNC_DELAY_EN to delay hs, vs and blank by one further pix_en stage.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       end_of_line;
  logic       end_of_frame;
  logic       hs_next;
  logic       vs_next;
  logic       blank_next;
  logic       hs_r;
  logic       vs_r;
  logic       blank_r;

  assign end_of_line  = (DrawX == H_LAST);
  assign end_of_frame = end_of_line && (DrawY == V_LAST);

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    x_next = DrawX;
    y_next = DrawY;
    if (pix_en) begin
      if (end_of_line) begin
        x_next = '0;
        y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
      end else begin
        x_next = DrawX + 10'd1;
      end
    end
  end

  // Decoded from the next position so the registered flags line up with DrawX/DrawY.
  assign hs_next    = ~((x_next >= HS_START) && (x_next < HS_STOP));
  assign vs_next    = ~((y_next >= VS_START) && (y_next < VS_STOP));
  assign blank_next = (x_next < H_VIS) && (y_next < V_VIS);

  // NOTE: non-blocking assignments for state, so every register samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      blank_r     <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= pix_en & end_of_frame;
      if (pix_en) begin
        DrawX   <= x_next;
        DrawY   <= y_next;
        hs_r    <= hs_next;
        vs_r    <= vs_next;
        blank_r <= blank_next;
        if (end_of_frame) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Extra stage matches the sprite stage's one-cycle colour register.
  logic hs_d;
  logic vs_d;
  logic blank_d;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      blank_d <= 1'b0;
    end else if (pix_en) begin
      hs_d    <= hs_r;
      vs_d    <= vs_r;
      blank_d <= blank_r;
    end
  end

  assign hs    = hs_d;
  assign vs    = vs_d;
  assign blank = blank_d;
`else
  assign hs    = hs_r;
  assign vs    = vs_r;
  assign blank = blank_r;
`endif

  assign sync = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and a small
// instance for whole-frame behaviour, both checked every cycle against a position model.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hfp; int hsw; int hbp;
    int vv; int vfp; int vsw; int vbp;
  } timing_t;

  localparam timing_t BIG   = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam timing_t SMALL = '{8, 2, 3, 3, 6, 1, 2, 2};

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic pix_en  = 1'b0;

  logic [9:0]  b_x, b_y, s_x, s_y;
  logic        b_hs, b_vs, b_blank, b_sync, b_fs;
  logic        s_hs, s_vs, s_blank, s_sync, s_fs;
  logic [15:0] b_fc, s_fc;

  vga_timing_gen dut_big (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs), .blank(b_blank),
    .sync(b_sync), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .sync(s_sync), .frame_start(s_fs), .frame_count(s_fc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model state: number of pix_en ticks since the last reset.
  longint n       = 0;
  logic   en_last = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      n       = 0;
      en_last = 1'b0;
    end else begin
      en_last = pix_en;
      if (pix_en) n = n + 1;
    end
  end

  // {hs, vs, blank} at tick k; tick 0 is the reset state.
  function automatic logic [2:0] ref_sync(input timing_t t, input longint k);
    longint ht, vt, x, y;
    logic h, v, b;
    if (k == 0) return 3'b110;
    ht = t.hv + t.hfp + t.hsw + t.hbp;
    vt = t.vv + t.vfp + t.vsw + t.vbp;
    x  = k % ht;
    y  = (k / ht) % vt;
    h  = !(x >= t.hv + t.hfp && x < t.hv + t.hfp + t.hsw);
    v  = !(y >= t.vv + t.vfp && y < t.vv + t.vfp + t.vsw);
    b  = (x < t.hv) && (y < t.vv);
    return {h, v, b};
  endfunction

  task automatic compare_inst(input string tag, input timing_t t,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic h, input logic v, input logic b,
                              input logic s, input logic fs, input logic [15:0] fc);
    longint ht, vt, fr;
    logic [2:0] sy;
    ht = t.hv + t.hfp + t.hsw + t.hbp;
    vt = t.vv + t.vfp + t.vsw + t.vbp;
    fr = ht * vt;
    sy = ref_sync(t, (DLY == 1 && n > 0) ? n - 1 : n);
    check({tag, ".DrawX"}, 32'(x), 32'(n % ht));
    check({tag, ".DrawY"}, 32'(y), 32'((n / ht) % vt));
    check({tag, ".hs"}, 32'(h), 32'(sy[2]));
    check({tag, ".vs"}, 32'(v), 32'(sy[1]));
    check({tag, ".blank"}, 32'(b), 32'(sy[0]));
    check({tag, ".sync"}, 32'(s), 32'd0);
    check({tag, ".frame_start"}, 32'(fs), 32'(en_last && n > 0 && (n % fr) == 0));
    check({tag, ".frame_count"}, 32'(fc), 32'((n / fr) % 65536));
  endtask

  logic chk_en = 1'b0;

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      compare_inst("big", BIG, b_x, b_y, b_hs, b_vs, b_blank, b_sync, b_fs, b_fc);
      compare_inst("small", SMALL, s_x, s_y, s_hs, s_vs, s_blank, s_sync, s_fs, s_fc);
    end
  end

  task automatic step(input logic en, input logic rst);
    pix_en  = en;
    reset_n = rst;
    @(posedge clk);
    #3;
  endtask

  initial begin
    int hs_low, first_low, blank_cnt, first_blank_lo;
    int fs_cnt, fs_x, fs_y, vs_low;

    // Reset held three cycles with pix_en high.
    step(1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst.DrawX", 32'(b_x), 32'd0);
    check("rst.DrawY", 32'(b_y), 32'd0);
    check("rst.hs", 32'(b_hs), 32'd1);
    check("rst.vs", 32'(b_vs), 32'd1);
    check("rst.blank", 32'(b_blank), 32'd0);
    check("rst.frame_count", 32'(b_fc), 32'd0);

    // First enabled cycle after release.
    step(1'b1, 1'b1);
    check("first.DrawX", 32'(b_x), 32'd1);
    check("first.DrawY", 32'(b_y), 32'd0);
    check("first.blank", 32'(b_blank), 32'(1 - DLY));
    check("first.hs", 32'(b_hs), 32'd1);
    check("first.frame_start", 32'(b_fs), 32'd0);

    // Horizontal timing over line 1 of the default instance.
    repeat (799) step(1'b1, 1'b1);
    check("line1.DrawX", 32'(b_x), 32'd0);
    check("line1.DrawY", 32'(b_y), 32'd1);
    hs_low = 0; first_low = -1; blank_cnt = 0; first_blank_lo = -1;
    for (int i = 0; i < 800; i++) begin
      step(1'b1, 1'b1);
      if (!b_hs) begin
        hs_low++;
        if (first_low < 0) first_low = int'(b_x);
      end
      if (b_blank) blank_cnt++;
      else if (first_blank_lo < 0) first_blank_lo = int'(b_x);
    end
    check("h.hs_low_cycles", 32'(hs_low), 32'd96);
    check("h.first_hs_low_x", 32'(first_low), 32'(656 + DLY));
    check("h.blank_cycles", 32'(blank_cnt), 32'd640);
    check("h.blank_fall_x", 32'(first_blank_lo), 32'(640 + DLY));

    // One full frame of the small instance (16 x 11 = 176 ticks).
    step(1'b1, 1'b0);
    check("frame.rst_fc", 32'(s_fc), 32'd0);
    fs_cnt = 0; fs_x = -1; fs_y = -1; vs_low = 0;
    for (int i = 0; i < 176; i++) begin
      step(1'b1, 1'b1);
      if (s_fs) begin
        fs_cnt++;
        fs_x = int'(s_x);
        fs_y = int'(s_y);
      end
      if (!s_vs) vs_low++;
    end
    check("frame.fs_pulses", 32'(fs_cnt), 32'd1);
    check("frame.fs_x", 32'(fs_x), 32'd0);
    check("frame.fs_y", 32'(fs_y), 32'd0);
    check("frame.frame_count", 32'(s_fc), 32'd1);
    check("frame.vs_low_cycles", 32'(vs_low), 32'd32);

    // Alternating enable across the second frame boundary.
    fs_cnt = 0;
    for (int i = 0; i < 180; i++) begin
      step(1'b1, 1'b1);
      if (s_fs) fs_cnt++;
      step(1'b0, 1'b1);
      if (s_fs) fs_cnt++;
    end
    check("gap.fs_cycles", 32'(fs_cnt), 32'd1);
    check("gap.frame_count", 32'(s_fc), 32'd2);
    check("gap.DrawX", 32'(s_x), 32'd4);
    check("gap.DrawY", 32'(s_y), 32'd0);

    // Reset mid-frame at DrawY = 4 of the small instance.
    repeat (60) step(1'b1, 1'b1);
    check("mid.DrawY_before", 32'(s_y), 32'd4);
    step(1'b1, 1'b0);
    check("mid.DrawX", 32'(s_x), 32'd0);
    check("mid.DrawY", 32'(s_y), 32'd0);
    check("mid.frame_count", 32'(s_fc), 32'd0);
    check("mid.frame_start", 32'(s_fs), 32'd0);
    fs_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1);
      if (s_fs) fs_cnt++;
    end
    check("mid.fs_pulses", 32'(fs_cnt), 32'd0);
    check("mid.frame_count_after", 32'(s_fc), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
